pe_act_bcast_sched: RTL

Per-PE scheduler that drives the weight-address-computation stage. It accepts one non-zero input activation at a time from the PE activation queue. Each accepted activation is broadcast over every output activation owned by this PE for the current layer. Every broadcast cycle produces one comp_en beat with layer, in/out indices, local output address and activation value. The block sits between the activation queue and the address-computation stage, and reports layer completion to the PE controller.

---
 rtl/pe_act_bcast_sched_pkg.sv | 19 +
 rtl/pe_act_bcast_sched_if.sv | 35 +++
 rtl/pe_act_bcast_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pe_act_bcast_sched_pkg.sv
// Shared PE definitions for the activation broadcast scheduler: bus widths,
// PE count and FSM state encoding.
package pe_act_bcast_sched_pkg;

  localparam int unsigned PeDataBus    = 16;
  localparam int unsigned PeAddrBus    = 16;
  localparam int unsigned PeActNoBus   = 6;
  localparam int unsigned PeLayerNoBus = 2;
  localparam int unsigned PeNum        = 64;
  localparam int unsigned PeNumLog2    = $clog2(PeNum);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StBcast = 2'd2,
    StDone  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/pe_act_bcast_sched_if.sv
// Activation-queue and computation-beat channels of the broadcast scheduler.
// master: the scheduler; slave: queue/address stage side.
interface pe_act_bcast_sched_if
  import pe_act_bcast_sched_pkg::*;
#(
  parameter int unsigned DATA_W   = PeDataBus,
  parameter int unsigned ADDR_W   = PeAddrBus,
  parameter int unsigned ACT_NO_W = PeActNoBus,
  parameter int unsigned LAYER_W  = PeLayerNoBus
);
  logic                in_act_valid;
  logic                in_act_ready;
  logic [ADDR_W-1:0]   in_act_idx_i;
  logic [DATA_W-1:0]   in_act_value_i;
  logic                in_act_last;
  logic                comp_stall;
  logic                comp_en;
  logic [LAYER_W-1:0]  layer_idx;
  logic [ADDR_W-1:0]   in_act_idx;
  logic [ADDR_W-1:0]   out_act_idx;
  logic [ACT_NO_W-1:0] out_act_addr;
  logic [DATA_W-1:0]   in_act_value;

  modport master (
    input  in_act_valid, in_act_idx_i, in_act_value_i, in_act_last, comp_stall,
    output in_act_ready, comp_en, layer_idx, in_act_idx, out_act_idx, out_act_addr,
           in_act_value
  );

  modport slave (
    output in_act_valid, in_act_idx_i, in_act_value_i, in_act_last, comp_stall,
    input  in_act_ready, comp_en, layer_idx, in_act_idx, out_act_idx, out_act_addr,
           in_act_value
  );
endinterface

// File: rtl/pe_act_bcast_sched.sv
// Per-PE scheduler broadcasting each accepted activation over all local output acts.
// Optional macro ACT_ZERO_SKIP_EN: zero-valued activations produce no beats.
module pe_act_bcast_sched
  import pe_act_bcast_sched_pkg::*;
#(
  parameter int unsigned DATA_W   = PeDataBus,
  parameter int unsigned ADDR_W   = PeAddrBus,
  parameter int unsigned ACT_NO_W = PeActNoBus,
  parameter int unsigned LAYER_W  = PeLayerNoBus
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          PE_IDX,
  input  logic                start,
  input  logic [LAYER_W-1:0]  cfg_layer_idx,
  input  logic [ACT_NO_W:0]   cfg_out_act_num,
  pe_act_bcast_sched_if.master bus,
  output logic                busy,
  output logic                layer_done
);

  localparam int unsigned CntW = ACT_NO_W + 1;

  sched_state_e        state_q, state_d;
  logic [LAYER_W-1:0]  layer_q, layer_d;
  logic [CntW-1:0]     num_q, num_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                last_q, last_d;

  logic                ready;
  logic                comp_en;
  logic                load;
  logic                skip;
  logic                final_beat;
  logic                in_bcast;
  logic [ADDR_W-1:0]   oidx;

  assign in_bcast   = (state_q == StBcast);
  assign final_beat = (cnt_q == num_q - CntW'(1));

`ifdef ACT_ZERO_SKIP_EN
  assign skip = (num_q == '0) || (bus.in_act_value_i == '0);
`else
  assign skip = (num_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    last_d  = last_q;
    ready   = 1'b0;
    comp_en = 1'b0;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          layer_d = cfg_layer_idx;
          num_d   = cfg_out_act_num;
          state_d = StLoad;
        end
      end
      StLoad: begin
        ready = 1'b1;
        load  = bus.in_act_valid;
      end
      StBcast: begin
        comp_en = ~bus.comp_stall;
        if (comp_en) begin
          if (!final_beat) begin
            cnt_d = cnt_q + CntW'(1);
          end else if (last_q) begin
            state_d = StDone;
          end else begin
            // Accepting on the final beat keeps the broadcast bubble-free.
            ready = 1'b1;
            load  = bus.in_act_valid;
            if (!bus.in_act_valid) state_d = StLoad;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (load) begin
      idx_d   = bus.in_act_idx_i;
      val_d   = bus.in_act_value_i;
      last_d  = bus.in_act_last;
      cnt_d   = '0;
      state_d = skip ? (bus.in_act_last ? StDone : StLoad) : StBcast;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      layer_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      last_q  <= last_d;
    end
  end

  // Output acts are interleaved across PEs: global index = local * PeNum + PE.
  assign oidx = (ADDR_W'(cnt_q) << PeNumLog2) + ADDR_W'(PE_IDX);

  assign bus.in_act_ready = ready;
  assign bus.comp_en      = comp_en;
  assign bus.layer_idx    = layer_q;
  assign bus.in_act_idx   = idx_q;
  assign bus.in_act_value = val_q;
  assign bus.out_act_addr = in_bcast ? cnt_q[ACT_NO_W-1:0] : '0;
  assign bus.out_act_idx  = in_bcast ? oidx : '0;
  assign busy             = (state_q != StIdle);
  assign layer_done       = (state_q == StDone);

endmodule
